// File: rtl/alu_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : alu_pipe                                                         |
// | Purpose : Registered WIDTH-bit ALU with valid/ready handshakes, status     |
// |           flags, a stored carry for ADC and an iterative shift-add         |
// |           multiplier that occupies the block for WIDTH cycles.             |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module alu_pipe #(
  parameter int WIDTH  = 4,
  parameter int MUL_EN = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic [3:0]       alu_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] alu_out_hi,
  output logic             carry_flag,
  output logic             zero_flag,
  output logic             neg_flag,
  output logic             ovf_flag,
  output logic             illegal_flag
);

  localparam logic [3:0] c_op_add = 4'h0;
  localparam logic [3:0] c_op_sub = 4'h1;
  localparam logic [3:0] c_op_and = 4'h2;
  localparam logic [3:0] c_op_or  = 4'h3;
  localparam logic [3:0] c_op_xor = 4'h4;
  localparam logic [3:0] c_op_not = 4'h5;
  localparam logic [3:0] c_op_shl = 4'h6;
  localparam logic [3:0] c_op_shr = 4'h7;
  localparam logic [3:0] c_op_rol = 4'h8;
  localparam logic [3:0] c_op_ror = 4'h9;
  localparam logic [3:0] c_op_adc = 4'hA;
  localparam logic [3:0] c_op_cmp = 4'hB;
  localparam logic [3:0] c_op_mul = 4'hC;

  // Counter must hold the value WIDTH itself (steps remaining at start).
  localparam int c_cnt_w = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     alu_out_q, alu_out_d;
  logic [WIDTH-1:0]     alu_hi_q, alu_hi_d;
  logic                 carry_q, carry_d;
  logic                 zero_q, zero_d;
  logic                 neg_q, neg_d;
  logic                 ovf_q, ovf_d;
  logic                 ill_q, ill_d;
  logic                 cst_q, cst_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [c_cnt_w-1:0]   cnt_q, cnt_d;

  logic [WIDTH:0]       w_add;
  logic [WIDTH:0]       w_adc;
  logic [WIDTH:0]       w_sub;
  logic [WIDTH-1:0]     w_res;
  logic                 w_cy;
  logic                 w_ov;
  logic                 w_ill;
  logic                 w_is_mul;
  logic                 w_accept;
  logic [WIDTH:0]       w_mul_sum;
  logic [2*WIDTH-1:0]   w_prod_next;

  // Extended-width arithmetic so the top bit is the carry/borrow.
  assign w_add = {1'b0, data_a} + {1'b0, data_b};
  assign w_adc = w_add + {{WIDTH{1'b0}}, cst_q};
  assign w_sub = {1'b0, data_a} - {1'b0, data_b};

  assign w_is_mul = (MUL_EN != 0) && (alu_sel == c_op_mul);

  // Reset input gates in_ready so nothing is taken while reset is held.
  assign in_ready = reset && (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign w_accept = in_valid && in_ready;

  // One shift-add step: low half holds the remaining multiplier bits,
  // high half accumulates; the pair shifts right every step.
  assign w_mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                       (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
  assign w_prod_next = {w_mul_sum, prod_q[WIDTH-1:1]};

  // Single-cycle op decode: result, carry, overflow and illegal detection.
  always_comb begin
    w_res = '0;
    w_cy  = 1'b0;
    w_ov  = 1'b0;
    w_ill = 1'b0;
    case (alu_sel)
      c_op_add: begin
        w_res = w_add[WIDTH-1:0];
        w_cy  = w_add[WIDTH];
        w_ov  = (data_a[WIDTH-1] == data_b[WIDTH-1]) && (w_add[WIDTH-1] != data_a[WIDTH-1]);
      end
      c_op_sub: begin
        w_res = w_sub[WIDTH-1:0];
        w_cy  = w_sub[WIDTH];
        w_ov  = (data_a[WIDTH-1] != data_b[WIDTH-1]) && (w_sub[WIDTH-1] != data_a[WIDTH-1]);
      end
      c_op_and: w_res = data_a & data_b;
      c_op_or:  w_res = data_a | data_b;
      c_op_xor: w_res = data_a ^ data_b;
      c_op_not: w_res = ~data_a;
      c_op_shl: begin
        w_res = {data_a[WIDTH-2:0], 1'b0};
        w_cy  = data_a[WIDTH-1];
      end
      c_op_shr: begin
        w_res = {1'b0, data_a[WIDTH-1:1]};
        w_cy  = data_a[0];
      end
      c_op_rol: w_res = {data_a[WIDTH-2:0], data_a[WIDTH-1]};
      c_op_ror: w_res = {data_a[0], data_a[WIDTH-1:1]};
      c_op_adc: begin
        w_res = w_adc[WIDTH-1:0];
        w_cy  = w_adc[WIDTH];
        w_ov  = (data_a[WIDTH-1] == data_b[WIDTH-1]) && (w_adc[WIDTH-1] != data_a[WIDTH-1]);
      end
      c_op_cmp: w_res = {{(WIDTH-1){1'b0}}, (data_a < data_b)};
      c_op_mul: w_ill = (MUL_EN == 0);
      default:  w_ill = 1'b1;
    endcase
  end

  // Next-state: accept/pop handshake, multiplier iteration, result load.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    alu_out_d   = alu_out_q;
    alu_hi_d    = alu_hi_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    ovf_d       = ovf_q;
    ill_d       = ill_q;
    cst_d       = cst_q;
    mcand_d     = mcand_q;
    prod_d      = prod_q;
    cnt_d       = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_is_mul) begin
            // Any previous result is being popped this edge (or none held).
            state_d     = ST_BUSY;
            out_valid_d = 1'b0;
            mcand_d     = data_a;
            prod_d      = {{WIDTH{1'b0}}, data_b};
            cnt_d       = c_cnt_w'(WIDTH);
          end else begin
            out_valid_d = 1'b1;
            alu_out_d   = w_res;
            alu_hi_d    = '0;
            carry_d     = w_cy;
            zero_d      = !w_ill && (w_res == '0);
            neg_d       = !w_ill && w_res[WIDTH-1];
            ovf_d       = w_ov;
            ill_d       = w_ill;
            cst_d       = w_cy;
          end
        end else if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
        end
      end
      ST_BUSY: begin
        prod_d = w_prod_next;
        cnt_d  = cnt_q - c_cnt_w'(1);
        if (cnt_q == c_cnt_w'(1)) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b1;
          alu_out_d   = w_prod_next[WIDTH-1:0];
          alu_hi_d    = w_prod_next[2*WIDTH-1:WIDTH];
          carry_d     = 1'b0;
          zero_d      = (w_prod_next == '0);
          neg_d       = w_prod_next[2*WIDTH-1];
          ovf_d       = 1'b0;
          ill_d       = 1'b0;
          cst_d       = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; asynchronous clear aborts any multiply.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      alu_out_q   <= '0;
      alu_hi_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
      ill_q       <= 1'b0;
      cst_q       <= 1'b0;
      mcand_q     <= '0;
      prod_q      <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      alu_out_q   <= alu_out_d;
      alu_hi_q    <= alu_hi_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      ovf_q       <= ovf_d;
      ill_q       <= ill_d;
      cst_q       <= cst_d;
      mcand_q     <= mcand_d;
      prod_q      <= prod_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign alu_out      = alu_out_q;
  assign alu_out_hi   = alu_hi_q;
  assign carry_flag   = carry_q;
  assign zero_flag    = zero_q;
  assign neg_flag     = neg_q;
  assign ovf_flag     = ovf_q;
  assign illegal_flag = ill_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_alu_pipe                                                      |
// | Purpose : Scoreboard bench for alu_pipe (WIDTH=4) plus a MUL_EN=0 copy.    |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_alu_pipe;

  localparam int W = 4;
  localparam int M = 16;
  localparam int H = 8;

  typedef struct packed {
    logic [3:0] out;
    logic [3:0] hi;
    logic       c;
    logic       z;
    logic       n;
    logic       v;
    logic       ill;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] data_a = '0;
  logic [3:0] data_b = '0;
  logic [3:0] alu_sel = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [3:0] alu_out, alu_out_hi;
  logic       carry_flag, zero_flag, neg_flag, ovf_flag, illegal_flag;

  logic       iv0 = 1'b0;
  logic       ir0;
  logic [3:0] a0 = '0, b0 = '0, sel0 = '0;
  logic       ov0;
  logic       ordy0 = 1'b1;
  logic [3:0] out0, hi0;
  logic       c0, z0, n0, v0, ill0;

  int   errors = 0;
  int   checks = 0;
  int   stalls = 0;
  int   rdy_mode = 0;   // 0: always ready, 1: never ready, 2: random
  int   m_cst = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(4), .MUL_EN(1)) dut (
    .clock(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .data_a(data_a), .data_b(data_b), .alu_sel(alu_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_out(alu_out), .alu_out_hi(alu_out_hi), .carry_flag(carry_flag),
    .zero_flag(zero_flag), .neg_flag(neg_flag), .ovf_flag(ovf_flag),
    .illegal_flag(illegal_flag)
  );

  alu_pipe #(.WIDTH(4), .MUL_EN(0)) dut0 (
    .clock(clk), .reset(reset), .in_valid(iv0), .in_ready(ir0),
    .data_a(a0), .data_b(b0), .alu_sel(sel0),
    .out_valid(ov0), .out_ready(ordy0),
    .alu_out(out0), .alu_out_hi(hi0), .carry_flag(c0),
    .zero_flag(z0), .neg_flag(n0), .ovf_flag(v0),
    .illegal_flag(ill0)
  );

  // Reference model: plain integer arithmetic on the op definitions.
  function automatic exp_t model(input int op, input int a, input int b, input int cst);
    exp_t e;
    int r = 0, hi = 0, s, sa, sb, p;
    bit c = 0, v = 0, ill = 0;
    sa = (a >= H) ? a - M : a;
    sb = (b >= H) ? b - M : b;
    case (op)
      0:  begin s = a + b; r = s % M; c = (s >= M); v = (sa + sb > H - 1) || (sa + sb < -H); end
      1:  begin s = a - b; r = (s + M) % M; c = (a < b); v = (sa - sb > H - 1) || (sa - sb < -H); end
      2:  r = a & b;
      3:  r = a | b;
      4:  r = a ^ b;
      5:  r = M - 1 - a;
      6:  begin r = (a * 2) % M; c = (a >= H); end
      7:  begin r = a / 2; c = (a % 2) != 0; end
      8:  r = (a * 2) % M + a / H;
      9:  r = a / 2 + (a % 2) * H;
      10: begin
        s = a + b + cst; r = s % M; c = (s >= M);
        v = (sa + sb + cst > H - 1) || (sa + sb + cst < -H);
      end
      11: r = (a < b) ? 1 : 0;
      12: begin p = a * b; r = p % M; hi = p / M; end
      default: ill = 1;
    endcase
    e.out = r[3:0];
    e.hi  = hi[3:0];
    e.c   = c;
    e.v   = v;
    e.ill = ill;
    e.z   = ill ? 1'b0 : ((r == 0) && (hi == 0));
    e.n   = ill ? 1'b0 : ((op == 12) ? (hi >= H) : (r >= H));
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present one op until it transfers; expectation is queued at the transfer.
  task automatic send(input int op, input int a, input int b);
    bit   took = 0;
    int   waited = 0;
    exp_t e;
    while (!took) begin
      @(negedge clk);
      in_valid = 1'b1;
      alu_sel  = op[3:0];
      data_a   = a[3:0];
      data_b   = b[3:0];
      #4;
      if (in_ready) begin
        took = 1;
      end else begin
        stalls++;
        waited++;
        if (waited > 100) begin
          checks++;
          errors++;
          $display("FAIL send_timeout: op %0h not accepted after %0d cycles", op, waited);
          in_valid = 1'b0;
          return;
        end
      end
    end
    e = model(op, a, b, m_cst);
    m_cst = (op == 12) ? 0 : int'(e.c);
    sb_q.push_back(e);
    @(posedge clk);
  endtask

  task automatic drop();
    @(negedge clk);
    in_valid = 1'b0;
    data_a   = 4'($urandom_range(0, 15));
    data_b   = 4'($urandom_range(0, 15));
    alu_sel  = 4'($urandom_range(0, 15));
  endtask

  task automatic drain();
    int n = 0;
    rdy_mode = 0;
    while (sb_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results pending, required 0", sb_q.size());
    end
  endtask

  function automatic int pick_single();
    int r = int'($urandom_range(0, 14));
    if (r >= 12) r++;
    return r;
  endfunction

  // Monitor: drives out_ready, pops/compares results, checks output hold.
  initial begin
    exp_t act, snap;
    exp_t e;
    bit   prev_held = 0;
    snap = '0;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      #4;
      act = {alu_out, alu_out_hi, carry_flag, zero_flag, neg_flag, ovf_flag, illegal_flag};
      if (!reset) begin
        prev_held = 0;
      end else begin
        if (prev_held) begin
          checks++;
          if (!out_valid || act != snap) begin
            errors++;
            $display("FAIL hold: got valid=%b outs=%h required valid=1 outs=%h", out_valid, act, snap);
          end
        end
        if (out_valid && !out_ready) chk("in_ready_while_held", int'(in_ready), 0);
        if (out_valid && out_ready) begin
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_result: got outs=%h required none", act);
          end else begin
            e = sb_q.pop_front();
            if (act != e) begin
              errors++;
              $display("FAIL result: got out=%h hi=%h c=%b z=%b n=%b v=%b ill=%b required out=%h hi=%h c=%b z=%b n=%b v=%b ill=%b",
                       act.out, act.hi, act.c, act.z, act.n, act.v, act.ill,
                       e.out, e.hi, e.c, e.z, e.n, e.v, e.ill);
            end
          end
        end
        prev_held = out_valid && !out_ready;
        snap = act;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int s0;
    // ---------------- reset state ----------------
    #12;
    chk("reset_in_ready", int'(in_ready), 0);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_outputs", int'({alu_out, alu_out_hi, carry_flag, zero_flag, neg_flag, ovf_flag, illegal_flag}), 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("in_ready_after_release", int'(in_ready), 1);

    // ---------------- MUL_EN=0 copy: op C is illegal ----------------
    @(negedge clk);
    iv0 = 1'b1; sel0 = 4'hC; a0 = 4'hB; b0 = 4'h7;
    #4;
    chk("mul_dis_in_ready", int'(ir0), 1);
    @(negedge clk);
    iv0 = 1'b0;
    #2;
    chk("mul_dis_valid", int'(ov0), 1);
    chk("mul_dis_illegal", int'(ill0), 1);
    chk("mul_dis_out", int'({out0, hi0}), 0);
    chk("mul_dis_flags", int'({c0, z0, n0, v0}), 0);

    // ---------------- directed single-cycle ops ----------------
    send(0, 15, 1);
    send(0, 7, 1);
    send(1, 3, 5);
    send(10, 2, 3);
    send(10, 2, 3);
    drop();
    drain();

    // ---------------- MUL latency B*7 ----------------
    send(12, 11, 7);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #2;
      chk("mul_busy_in_ready", int'(in_ready), 0);
      chk("mul_busy_out_valid", int'(out_valid), 0);
      @(posedge clk);
    end
    @(negedge clk);
    #2;
    chk("mul_done_valid", int'(out_valid), 1);
    chk("mul_done_lo", int'(alu_out), 'hD);
    chk("mul_done_hi", int'(alu_out_hi), 'h4);
    drain();

    // ---------------- backpressure ----------------
    rdy_mode = 1;
    send(0, 2, 3);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      in_valid = 1'b1; alu_sel = 4'h4; data_a = 4'h9; data_b = 4'h6;
      #4;
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_alu_out", int'(alu_out), 5);
    end
    rdy_mode = 0;
    send(4, 9, 6);
    drop();
    drain();

    // ---------------- back-to-back full throughput ----------------
    s0 = stalls;
    for (int j = 0; j < 8; j++) begin
      send(pick_single(), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    end
    chk("b2b_stalls", stalls - s0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    chk("b2b_pending", sb_q.size(), 1);
    drain();

    // ---------------- randomized traffic with random backpressure ----------------
    rdy_mode = 2;
    for (int j = 0; j < 150; j++) begin
      if ($urandom_range(0, 3) == 0) drop();
      if ($urandom_range(0, 5) == 0)
        send(12, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      else
        send(pick_single(), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    end
    drop();
    drain();

    // ---------------- reset during MUL ----------------
    send(1, 3, 5);
    drop();
    drain();
    send(12, 15, 15);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("rst_mul_valid", int'(out_valid), 0);
    chk("rst_mul_outputs", int'({alu_out, alu_out_hi, carry_flag, zero_flag, neg_flag, ovf_flag, illegal_flag}), 0);
    chk("rst_mul_in_ready", int'(in_ready), 0);
    sb_q.delete();
    m_cst = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      #2;
      chk("no_stale_result", int'(out_valid), 0);
    end
    send(0, 1, 1);
    send(10, 1, 1);
    drop();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
